display_arbiter: RTL and testbench

//  Shares the two-digit seven-segment display between NREQ requesters (switch readout, counters, status).

---
 rtl/display_arbiter.sv | 129 ++++++++++++
 tb/tb_display_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - round-robin owner arbiter for the shared two-digit display
// Grants the display to one requester at a time, holding it for a minimum time against contention.
module display_arbiter #(
  parameter int NREQ       = 3,
  parameter int TICK_DIV   = 12000000,
  parameter int HOLD_TICKS = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     gnt,
  output logic [7:0]          disp_val,
  output logic                disp_blank,
  output logic                busy
);

  localparam int IW = $clog2(NREQ);
  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [NREQ-1:0] gnt_d;
  logic [7:0]      disp_d;
  logic            tick, hold_done;
  logic [IW:0]     pick_any, pick_other;

  // Returns {found, index}: first set bit of mask scanning ptr, ptr+1, ... mod NREQ.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] mask, input logic [IW-1:0] ptr);
    logic          found;
    logic [IW-1:0] win;
    logic [IW:0]   idx;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(NREQ)) idx = idx - (IW+1)'(NREQ);
      if (!found && mask[idx[IW-1:0]]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end
    end
    return {found, win};
  endfunction

  function automatic logic [7:0] byte_of(input logic [8*NREQ-1:0] data, input logic [IW-1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < NREQ; i++)
      if (idx == IW'(i)) b = data[8*i +: 8];
    return b;
  endfunction

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] win);
    return (win == IW'(NREQ-1)) ? '0 : win + IW'(1);
  endfunction

  assign tick       = (presc_q == PW'(TICK_DIV-1));
  // Expiry is seen one cycle early so the hold lasts exactly HOLD_TICKS*TICK_DIV cycles.
  assign hold_done  = (hold_q == '0) || ((hold_q == HW'(1)) && tick);
  assign pick_any   = rr_pick(req, rr_ptr_q);
  assign pick_other = rr_pick(req & ~gnt, rr_ptr_q);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    presc_d  = presc_q;
    hold_d   = hold_q;
    case (state_q)
      IDLE: begin
        if (pick_any[IW]) begin
          state_d  = OWN;
          owner_d  = pick_any[IW-1:0];
          rr_ptr_d = next_ptr(pick_any[IW-1:0]);
          presc_d  = '0;
          hold_d   = HW'(HOLD_TICKS);
        end
      end
      OWN: begin
        if (!req[owner_q]) begin
          state_d = IDLE;
        end else if (hold_done && pick_other[IW]) begin
          owner_d  = pick_other[IW-1:0];
          rr_ptr_d = next_ptr(pick_other[IW-1:0]);
          presc_d  = '0;
          hold_d   = HW'(HOLD_TICKS);
        end else begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick && hold_q != '0) hold_d = hold_q - HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_d  = (state_d == OWN) ? ({{(NREQ-1){1'b0}}, 1'b1} << owner_d) : '0;
    disp_d = (state_d == OWN) ? byte_of(req_data, owner_d) : 8'h00;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      presc_q    <= '0;
      hold_q     <= '0;
      gnt        <= '0;
      disp_val   <= 8'h00;
      disp_blank <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      presc_q    <= presc_d;
      hold_q     <= hold_d;
      gnt        <= gnt_d;
      disp_val   <= disp_d;
      disp_blank <= (state_d != OWN);
      busy       <= (state_d == OWN);
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - directed scoreboard bench for display_arbiter
// Expected grant/byte pairs are queued with each stimulus step and compared per clock.
module tb_display_arbiter;

  logic        CLK;
  logic        RST_N;
  logic [2:0]  req;
  logic [7:0]  d0, d1, d2;
  logic [23:0] req_data;
  logic [2:0]  gnt;
  logic [7:0]  disp_val;
  logic        disp_blank;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [10:0] sb_q[$];
  string       tag_q[$];

  assign req_data = {d2, d1, d0};

  display_arbiter #(.NREQ(3), .TICK_DIV(4), .HOLD_TICKS(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .req(req), .req_data(req_data),
    .gnt(gnt), .disp_val(disp_val), .disp_blank(disp_blank), .busy(busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] g, input logic [7:0] v, input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back({g, v});
      tag_q.push_back($sformatf("%s[%0d]", tag, i));
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".gnt"},   {5'b0, gnt}, 8'h00);
    chk({tag, ".val"},   disp_val,    8'h00);
    chk({tag, ".blank"}, {7'b0, disp_blank}, 8'h01);
    chk({tag, ".busy"},  {7'b0, busy},       8'h00);
  endtask

  // One queue entry per rising edge; sampled 1 time unit after the edge.
  task automatic drain();
    logic [10:0] e;
    string       t;
    while (sb_q.size() > 0) begin
      @(posedge CLK);
      #1;
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      chk({t, ".gnt"},   {5'b0, gnt},        {5'b0, e[10:8]});
      chk({t, ".val"},   disp_val,           e[7:0]);
      chk({t, ".blank"}, {7'b0, disp_blank}, {7'b0, (e[10:8] == 3'b000)});
      chk({t, ".busy"},  {7'b0, busy},       {7'b0, (e[10:8] != 3'b000)});
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    req   = 3'b000;
    RST_N = 1'b0;
    #2;
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b1;
    req   = 3'b000;
    d0 = 8'h00; d1 = 8'h00; d2 = 8'h00;

    // async reset before any clock edge
    #3;
    req   = 3'($urandom_range(0, 7));
    RST_N = 1'b0;
    #1;
    check_idle("rst_async");
    @(negedge CLK);
    req   = 3'b000;
    RST_N = 1'b1;

    // single requester, live data, drop
    @(negedge CLK);
    d0 = 8'h3A; req = 3'b001;
    push(3'b001, 8'h3A, "single_grant", 1);
    drain();
    @(negedge CLK);
    d0 = 8'h5C;
    push(3'b001, 8'h5C, "live_data", 1);
    drain();
    @(negedge CLK);
    req = 3'b000;
    push(3'b000, 8'h00, "drop_blank", 2);
    drain();

    // two requesters: 8-cycle holds, direct handover
    do_reset();
    @(negedge CLK);
    d0 = 8'h11; d2 = 8'h22; req = 3'b101;
    push(3'b001, 8'h11, "rr2_own0", 8);
    push(3'b100, 8'h22, "rr2_own2", 8);
    push(3'b001, 8'h11, "rr2_back0", 1);
    drain();

    // three requesters: full rotation
    do_reset();
    @(negedge CLK);
    d0 = 8'h0A; d1 = 8'h0B; d2 = 8'h0C; req = 3'b111;
    push(3'b001, 8'h0A, "rr3_own0", 8);
    push(3'b010, 8'h0B, "rr3_own1", 8);
    push(3'b100, 8'h0C, "rr3_own2", 8);
    push(3'b001, 8'h0A, "rr3_wrap0", 1);
    drain();

    // owner drops mid-hold: one blank cycle then next requester
    do_reset();
    @(negedge CLK);
    d0 = 8'h41; d1 = 8'h42; req = 3'b011;
    push(3'b001, 8'h41, "drop_own0", 3);
    drain();
    @(negedge CLK);
    req = 3'b010;
    push(3'b000, 8'h00, "drop_gap", 1);
    push(3'b010, 8'h42, "drop_own1", 3);
    drain();

    // lone owner past hold, late contender, short pulse lost
    do_reset();
    @(negedge CLK);
    d0 = 8'h77; d2 = 8'h99; req = 3'b001;
    push(3'b001, 8'h77, "alone_own0", 30);
    drain();
    @(negedge CLK);
    req = 3'b101;
    push(3'b100, 8'h99, "late_own2", 1);
    drain();
    @(negedge CLK);
    req = 3'b111;
    push(3'b100, 8'h99, "pulse1_hold", 3);
    drain();
    @(negedge CLK);
    req = 3'b101;
    push(3'b100, 8'h99, "pulse1_gone", 4);
    push(3'b001, 8'h77, "skip1_own0", 1);
    drain();

    // async reset mid-grant
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check_idle("rst_midgrant");
    @(negedge CLK);
    RST_N = 1'b1;
    req   = 3'b000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
